// File: rtl/iobus_dec.sv
// I/O-window decoder: N device slots, status slot 15, bus watchdog.
// Optional irq mask register under IOBUS_DEC_IRQMASK_EN.
module iobus_dec #(
    parameter int AW = 22,
    parameter int SW = 1,
    parameter int NSLV = 8,
    parameter logic [AW-SW-5:0] BASE = 'h3FFF,
    parameter int TMO = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m_stb,
    input  logic                 m_we,
    input  logic [AW-1:0]        m_addr,
    input  logic [31:0]          m_wdata,
    output logic [31:0]          m_rdata,
    output logic                 m_ack,
    output logic [NSLV-1:0]      s_stb,
    input  logic [32*NSLV-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ack,
    input  logic [NSLV-1:0]      s_irq,
    output logic [NSLV-1:0]      irq,
    output logic                 err_irq
);

    localparam int WSW = (SW > 0) ? SW : 1;

    logic           hit;
    logic [3:0]     slot;
    logic [WSW-1:0] wsel;
    logic           st_sel;
    logic           st_ack;
    logic           dev_ack;
    logic [31:0]    dev_rdata;
    logic [31:0]    st_rdata;
    logic           sel_ack;
    logic           tmo;
    logic           wr0;
    logic [7:0]     cnt;
    logic           err;
    logic           err_we;
    logic [AW-1:0]  err_addr;

    assign hit    = m_stb & (m_addr[AW-1:SW+4] == BASE);
    assign slot   = m_addr[SW+3:SW];
    assign st_sel = (slot == 4'hF);

    generate
        if (SW > 0) begin : g_wsel
            assign wsel = m_addr[WSW-1:0];
        end else begin : g_nowsel
            assign wsel = '0;
        end
    endgenerate

    always_comb begin
        s_stb     = '0;
        dev_ack   = 1'b0;
        dev_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (slot == 4'(i)) begin
                s_stb[i]  = hit;
                dev_ack   = s_ack[i];
                dev_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    assign sel_ack = hit & (st_sel ? st_ack : dev_ack);
    assign tmo     = hit & ~sel_ack & (cnt == 8'(TMO - 1));
    assign m_ack   = sel_ack | tmo;
    assign wr0     = hit & st_sel & st_ack & m_we & (wsel == '0);
    assign err_irq = err;

`ifdef IOBUS_DEC_IRQMASK_EN
    logic [NSLV-1:0] mask;
    logic            wr1;

    assign wr1 = hit & st_sel & st_ack & m_we & (wsel == WSW'(1));
    assign irq = s_irq & mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '1;
        end else if (wr1) begin
            mask <= m_wdata[NSLV-1:0];
        end
    end

    always_comb begin
        st_rdata = '0;
        if (wsel == '0) begin
            st_rdata = {err, err_we, 30'(err_addr)};
        end else if (wsel == WSW'(1)) begin
            st_rdata = 32'(mask);
        end
    end
`else
    assign irq = s_irq;

    always_comb begin
        st_rdata = '0;
        if (wsel == '0) begin
            st_rdata = {err, err_we, 30'(err_addr)};
        end
    end
`endif

    logic unused_wdata;
    assign unused_wdata = ^m_wdata;

    // A timeout cycle forces zero data; unmapped slots already read zero.
    always_comb begin
        m_rdata = '0;
        if (hit && !tmo) begin
            m_rdata = st_sel ? st_rdata : dev_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_ack   <= 1'b0;
            cnt      <= '0;
            err      <= 1'b0;
            err_we   <= 1'b0;
            err_addr <= '0;
        end else begin
            st_ack <= hit & st_sel & ~st_ack;
            if (!hit || sel_ack || tmo) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
            // Clearing drops the whole error record; first error wins otherwise.
            if (wr0) begin
                err      <= 1'b0;
                err_we   <= 1'b0;
                err_addr <= '0;
            end else if (tmo && !err) begin
                err      <= 1'b1;
                err_we   <= m_we;
                err_addr <= m_addr;
            end
        end
    end

endmodule

// File: tb/tb_iobus_dec.sv
// Randomised bench for iobus_dec against a transaction-level model.
// Honours IOBUS_DEC_IRQMASK_EN for the irq-mask expectations.
module tb_iobus_dec;

    localparam int AW = 22;
    localparam int SW = 1;
    localparam int NSLV = 8;
    localparam int TMO = 64;
    localparam logic [16:0] TAG = 17'h3FFF;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                m_stb;
    logic                m_we;
    logic [AW-1:0]       m_addr;
    logic [31:0]         m_wdata;
    logic [31:0]         m_rdata;
    logic                m_ack;
    logic [NSLV-1:0]     s_stb;
    logic [32*NSLV-1:0]  s_rdata;
    logic [NSLV-1:0]     s_ack;
    logic [NSLV-1:0]     s_irq;
    logic [NSLV-1:0]     irq;
    logic                err_irq;

    int total = 0;
    int bad = 0;

    logic            mdl_err;
    logic            mdl_err_we;
    logic [AW-1:0]   mdl_err_addr;
    logic [NSLV-1:0] mdl_mask;

    iobus_dec #(
        .AW(AW), .SW(SW), .NSLV(NSLV), .BASE(17'h3FFF), .TMO(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
        .s_stb(s_stb), .s_rdata(s_rdata), .s_ack(s_ack),
        .s_irq(s_irq), .irq(irq), .err_irq(err_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] mk_addr(input logic [3:0] slot,
                                              input logic word);
        return {TAG, slot, word};
    endfunction

    function automatic logic [31:0] status_word(input logic word);
        if (word == 1'b0)
            return (32'(mdl_err) << 31) | (32'(mdl_err_we) << 30)
                   | 32'(mdl_err_addr);
`ifdef IOBUS_DEC_IRQMASK_EN
        return 32'(mdl_mask);
`else
        return 32'h0;
`endif
    endfunction

    function automatic int exp_ack(input logic [3:0] slot, input int ack_at);
        if (slot < NSLV && ack_at >= 1 && ack_at <= TMO) return ack_at;
        if (slot == 4'hF) return 2;
        return TMO;
    endfunction

    function automatic bit is_tmo(input logic [3:0] slot, input int ack_at);
        return (slot != 4'hF) && !(slot < NSLV && ack_at >= 1 && ack_at <= TMO);
    endfunction

    task automatic model_reset();
        mdl_err = 1'b0;
        mdl_err_we = 1'b0;
        mdl_err_addr = '0;
        mdl_mask = '1;
    endtask

    task automatic model_commit(input logic we, input logic [3:0] slot,
                                input logic word, input logic [31:0] wdata,
                                input int ack_at);
        if (is_tmo(slot, ack_at) && !mdl_err) begin
            mdl_err = 1'b1;
            mdl_err_we = we;
            mdl_err_addr = mk_addr(slot, word);
        end
        if (slot == 4'hF && we && word == 1'b0) begin
            mdl_err = 1'b0;
            mdl_err_we = 1'b0;
            mdl_err_addr = '0;
        end
`ifdef IOBUS_DEC_IRQMASK_EN
        if (slot == 4'hF && we && word == 1'b1) mdl_mask = wdata[NSLV-1:0];
`endif
    endtask

    task automatic bus_access(input logic we, input logic [3:0] slot,
                              input logic word, input logic [31:0] wdata,
                              input int ack_at, input logic [31:0] dev_data,
                              output int ack_cyc, output logic [31:0] rdata,
                              output logic [NSLV-1:0] stb1);
        ack_cyc = 0;
        rdata = '0;
        stb1 = '0;
        for (int i = 0; i < NSLV; i++) s_rdata[32*i +: 32] = $urandom;
        for (int c = 1; c <= TMO + 8; c++) begin
            @(negedge clk);
            m_stb = 1'b1;
            m_we = we;
            m_addr = mk_addr(slot, word);
            m_wdata = wdata;
            s_ack = '0;
            if (slot < NSLV) begin
                s_rdata[32*slot +: 32] = dev_data;
                s_ack[slot] = (c == ack_at);
            end
            #1;
            if (c == 1) stb1 = s_stb;
            if (m_ack) begin
                ack_cyc = c;
                rdata = m_rdata;
                break;
            end
        end
        @(negedge clk);
        m_stb = 1'b0;
        m_we = 1'b0;
        s_ack = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_stb = 1'b0;
        m_we = 1'b0;
        m_addr = '0;
        m_wdata = '0;
        s_rdata = '0;
        s_ack = '0;
        s_irq = '1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (m_ack !== 1'b0) begin
            bad++; $display("FAIL reset_ack: got %b want 0", m_ack);
        end
        total++;
        if (s_stb !== '0) begin
            bad++; $display("FAIL reset_stb: got %h want 0", s_stb);
        end
        total++;
        if (err_irq !== 1'b0) begin
            bad++; $display("FAIL reset_err_irq: got %b want 0", err_irq);
        end
        total++;
        if (irq !== 8'hFF) begin
            bad++; $display("FAIL reset_irq: got %h want ff", irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_device_read();
        int ac;
        int at;
        logic [31:0] rd;
        logic [31:0] d;
        logic [NSLV-1:0] st;
        logic [3:0] sl;
        logic we;
        bus_access(1'b0, 4'd2, 1'b0, 32'h0, 3, 32'hCAFEBABE, ac, rd, st);
        total++;
        if (st !== 8'b00000100) begin
            bad++; $display("FAIL dev_stb: got %b want 00000100", st);
        end
        total++;
        if (ac !== 3) begin
            bad++; $display("FAIL dev_ack_cycle: got %0d want 3", ac);
        end
        total++;
        if (rd !== 32'hCAFEBABE) begin
            bad++; $display("FAIL dev_rdata: got %h want cafebabe", rd);
        end
        #1;
        total++;
        if (err_irq !== 1'b0) begin
            bad++; $display("FAIL dev_err_irq: got %b want 0", err_irq);
        end
        for (int n = 0; n < 16; n++) begin
            sl = 4'($urandom_range(0, NSLV - 1));
            at = $urandom_range(1, 10);
            d = $urandom;
            we = 1'($urandom);
            bus_access(we, sl, 1'b0, $urandom, at, d, ac, rd, st);
            total++;
            if (st !== (8'd1 << sl)) begin
                bad++; $display("FAIL rnd_stb: got %b want slot %0d", st, sl);
            end
            total++;
            if (ac !== at) begin
                bad++; $display("FAIL rnd_ack_cycle: got %0d want %0d", ac, at);
            end
            total++;
            if (rd !== d) begin
                bad++; $display("FAIL rnd_rdata: got %h want %h", rd, d);
            end
            model_commit(we, sl, 1'b0, 32'h0, at);
        end
    endtask

    task automatic test_miss();
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            m_stb = 1'b1;
            m_addr = {TAG ^ 17'($urandom_range(1, 131071)),
                      4'($urandom), 1'($urandom)};
            s_ack = '1;
            for (int i = 0; i < NSLV; i++) s_rdata[32*i +: 32] = $urandom;
            #1;
            total++;
            if (m_ack !== 1'b0 || s_stb !== '0 || m_rdata !== '0) begin
                bad++;
                $display("FAIL miss: got ack=%b stb=%h rdata=%h want 0/0/0",
                         m_ack, s_stb, m_rdata);
            end
        end
        @(negedge clk);
        m_stb = 1'b0;
        s_ack = '0;
    endtask

    task automatic test_timeout();
        int ac;
        logic [31:0] rd;
        logic [31:0] want;
        logic [NSLV-1:0] st;
        bus_access(1'b0, 4'd3, 1'b0, 32'h0, TMO, 32'h1234_5678, ac, rd, st);
        model_commit(1'b0, 4'd3, 1'b0, 32'h0, TMO);
        total++;
        if (ac !== TMO || rd !== 32'h1234_5678) begin
            bad++; $display("FAIL late_ack: got %0d/%h want %0d/12345678",
                            ac, rd, TMO);
        end
        #1;
        total++;
        if (err_irq !== 1'b0) begin
            bad++; $display("FAIL late_ack_err: got %b want 0", err_irq);
        end
        bus_access(1'b1, 4'd10, 1'b0, 32'hDEAD, 0, 32'h0, ac, rd, st);
        model_commit(1'b1, 4'd10, 1'b0, 32'hDEAD, 0);
        total++;
        if (ac !== TMO || rd !== 32'h0) begin
            bad++; $display("FAIL tmo_ack: got %0d/%h want %0d/0", ac, rd, TMO);
        end
        total++;
        if (st !== '0) begin
            bad++; $display("FAIL tmo_stb: got %h want 0", st);
        end
        #1;
        total++;
        if (err_irq !== 1'b1) begin
            bad++; $display("FAIL tmo_err_irq: got %b want 1", err_irq);
        end
        want = status_word(1'b0);
        bus_access(1'b0, 4'hF, 1'b0, 32'h0, 0, 32'h0, ac, rd, st);
        total++;
        if (ac !== 2 || rd !== want) begin
            bad++; $display("FAIL status_rd: got %0d/%h want 2/%h", ac, rd, want);
        end
    endtask

    task automatic test_second_timeout();
        int ac;
        logic [31:0] rd;
        logic [31:0] want;
        logic [NSLV-1:0] st;
        bus_access(1'b0, 4'd12, 1'b0, 32'h0, 0, 32'h0, ac, rd, st);
        model_commit(1'b0, 4'd12, 1'b0, 32'h0, 0);
        total++;
        if (ac !== TMO || rd !== 32'h0) begin
            bad++; $display("FAIL tmo2_ack: got %0d/%h want %0d/0", ac, rd, TMO);
        end
        want = status_word(1'b0);
        bus_access(1'b0, 4'hF, 1'b0, 32'h0, 0, 32'h0, ac, rd, st);
        total++;
        if (rd !== want) begin
            bad++; $display("FAIL tmo2_status: got %h want %h", rd, want);
        end
        total++;
        if (rd[AW-1:0] !== mk_addr(4'd10, 1'b0)) begin
            bad++; $display("FAIL tmo2_addr: got %h want %h",
                            rd[AW-1:0], mk_addr(4'd10, 1'b0));
        end
    endtask

    task automatic test_status_clear();
        int ac;
        logic [31:0] rd;
        logic [NSLV-1:0] st;
        bus_access(1'b1, 4'hF, 1'b0, $urandom, 0, 32'h0, ac, rd, st);
        model_commit(1'b1, 4'hF, 1'b0, 32'h0, 0);
        total++;
        if (ac !== 2) begin
            bad++; $display("FAIL clr_ack: got %0d want 2", ac);
        end
        #1;
        total++;
        if (err_irq !== 1'b0) begin
            bad++; $display("FAIL clr_err_irq: got %b want 0", err_irq);
        end
        bus_access(1'b0, 4'hF, 1'b0, 32'h0, 0, 32'h0, ac, rd, st);
        total++;
        if (rd !== 32'h0 || rd !== status_word(1'b0)) begin
            bad++; $display("FAIL clr_status: got %h want 0", rd);
        end
    endtask

    task automatic test_reset_mid();
        int ac;
        int seen;
        logic [31:0] rd;
        logic [NSLV-1:0] st;
        bus_access(1'b0, 4'd13, 1'b0, 32'h0, 0, 32'h0, ac, rd, st);
        model_commit(1'b0, 4'd13, 1'b0, 32'h0, 0);
        #1;
        total++;
        if (err_irq !== 1'b1) begin
            bad++; $display("FAIL pre_rst_err: got %b want 1", err_irq);
        end
        seen = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            m_stb = 1'b1;
            m_we = 1'b0;
            m_addr = mk_addr(4'd11, 1'b0);
            if (c == 30) rst_n = 1'b0;
            #1;
            if (m_ack) seen++;
        end
        total++;
        if (err_irq !== 1'b0) begin
            bad++; $display("FAIL rst_err_irq: got %b want 0", err_irq);
        end
        model_reset();
        repeat (3) begin
            @(negedge clk);
            #1;
            if (m_ack) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL rst_no_ack: got %0d acks want 0", seen);
        end
        @(negedge clk);
        m_stb = 1'b0;
        rst_n = 1'b1;
        bus_access(1'b0, 4'd11, 1'b0, 32'h0, 0, 32'h0, ac, rd, st);
        model_commit(1'b0, 4'd11, 1'b0, 32'h0, 0);
        total++;
        if (ac !== TMO) begin
            bad++; $display("FAIL rst_fresh_tmo: got %0d want %0d", ac, TMO);
        end
    endtask

    task automatic test_irq();
        int ac;
        logic [31:0] rd;
        logic [31:0] want;
        logic [NSLV-1:0] st;
        bus_access(1'b1, 4'hF, 1'b1, 32'h05, 0, 32'h0, ac, rd, st);
        model_commit(1'b1, 4'hF, 1'b1, 32'h05, 0);
        total++;
        if (ac !== 2) begin
            bad++; $display("FAIL mask_wr_ack: got %0d want 2", ac);
        end
        s_irq = 8'hFF;
        #1;
        total++;
`ifdef IOBUS_DEC_IRQMASK_EN
        if (irq !== 8'h05) begin
            bad++; $display("FAIL irq_masked: got %h want 05", irq);
        end
`else
        if (irq !== 8'hFF) begin
            bad++; $display("FAIL irq_unmasked: got %h want ff", irq);
        end
`endif
        want = status_word(1'b1);
        bus_access(1'b0, 4'hF, 1'b1, 32'h0, 0, 32'h0, ac, rd, st);
        total++;
        if (ac !== 2 || rd !== want) begin
            bad++; $display("FAIL mask_rd: got %0d/%h want 2/%h", ac, rd, want);
        end
        for (int n = 0; n < 6; n++) begin
            s_irq = NSLV'($urandom);
            #1;
            total++;
            if (irq !== (s_irq & mdl_mask)) begin
                bad++; $display("FAIL irq_rnd: got %h want %h",
                                irq, s_irq & mdl_mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ac;
        int at;
        int kind;
        logic [31:0] rd;
        logic [31:0] d;
        logic [31:0] wd;
        logic [31:0] want;
        logic [NSLV-1:0] st;
        logic [3:0] sl;
        logic we;
        logic wo;
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 9);
            we = 1'($urandom);
            wo = 1'b0;
            at = $urandom_range(1, 12);
            d = $urandom;
            wd = $urandom;
            if (kind == 0) begin
                sl = 4'($urandom_range(NSLV, 14));
                at = 0;
            end else if (kind <= 3) begin
                sl = 4'hF;
                wo = 1'($urandom);
            end else begin
                sl = 4'($urandom_range(0, NSLV - 1));
            end
            if (sl == 4'hF) want = status_word(wo);
            else if (is_tmo(sl, at)) want = 32'h0;
            else want = d;
            bus_access(we, sl, wo, wd, at, d, ac, rd, st);
            total++;
            if (ac !== exp_ack(sl, at)) begin
                bad++; $display("FAIL b2b_ack slot %0d: got %0d want %0d",
                                sl, ac, exp_ack(sl, at));
            end
            if (!we || is_tmo(sl, at)) begin
                total++;
                if (rd !== want) begin
                    bad++; $display("FAIL b2b_rdata slot %0d: got %h want %h",
                                    sl, rd, want);
                end
            end
            model_commit(we, sl, wo, wd, at);
            #1;
            total++;
            if (err_irq !== mdl_err) begin
                bad++; $display("FAIL b2b_err_irq: got %b want %b",
                                err_irq, mdl_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_device_read();
        test_miss();
        test_timeout();
        test_second_timeout();
        test_status_clear();
        test_reset_mid();
        test_irq();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iobus_dec.md
Name: iobus_dec

Overview:
- Parametrised I/O-window decoder and interconnect for the RISC5 system bus.
- Replaces hand-written per-device strobe, data and ack muxing with an N-slot decoder.
- Adds a bus-timeout watchdog, an error-capture status register and an interrupt mask.
- Sits between the CPU bus and all I/O devices inside one aligned address window.

Parameters:
- AW, 22: word-address width; bus address bits AW+1:2.
- SW, 1: log2 of words per slot.
- NSLV, 8: number of device slots, 1..15. Slot 15 is always the internal status slot.
- BASE, 'h3FFF: window tag, compared with m_addr[AW+1:SW+6]; width AW-SW-4 bits.
- TMO, 64: timeout in cycles, 2..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active low.
- m_stb  in  1  bus strobe from the CPU.
- m_we  in  1  bus write enable.
- m_addr  in  AW  word address, bits AW+1:2.
- m_wdata  in  32  write data.
- m_rdata  out  32  read data to the CPU.
- m_ack  out  1  acknowledge to the CPU.
- s_stb  out  NSLV  one-hot slot strobes.
- s_rdata  in  32*NSLV  slave read data; slot i occupies bits 32i+31:32i.
- s_ack  in  NSLV  slave acknowledges.
- s_irq  in  NSLV  slave interrupt requests.
- irq  out  NSLV  masked interrupt requests.
- err_irq  out  1  bus-error interrupt.

Behaviour:
- Reset is asynchronous and active low. Reset values: err=0, err_we=0, err_addr=0, cnt=0, st_ack=0, mask=all ones. Hence m_ack=0, s_stb=0, err_irq=0.
- hit = m_stb & (m_addr[AW+1:SW+6]==BASE). slot = m_addr[SW+5:SW+2].
- s_stb[i] = hit & (slot==i) & (i<NSLV). Combinational, no added latency.
- Device slot: m_rdata and m_ack pass through combinationally from s_rdata and s_ack of the selected slot.
- Status slot 15:
  - Registered ack: st_ack <= hit & (slot==15) & ~st_ack. This gives a one-cycle pulse one cycle after the strobe.
  - Read word 0: {err, err_we, 30-AW zero bits, err_addr}.
  - Write word 0, any data: clears err on the ack cycle.
- Unmapped slots (NSLV..14): no s_stb is asserted. These are serviced only by the timeout.
- No hit: m_ack=0 and m_rdata=0.
- Watchdog:
  - cnt increments each cycle that hit is high and the selected ack is low.
  - cnt clears when hit is low or any ack is given.
  - When cnt==TMO-1 and the selected ack is low, m_ack=1 and m_rdata=0 for that cycle, and cnt clears.
  - Same timeout cycle, if err==0: err<=1, err_we<=m_we, err_addr<=m_addr. The first error wins; later timeouts do not overwrite.
  - A real ack in the TMO-1 cycle has priority; no error is recorded.
- err_irq = err, registered.
- irq = s_irq & mask, combinational.
- Slaves must hold s_ack low once the strobe drops. A late slave ack after a timeout is ignored because s_stb has fallen.
- Reset mid-access: cnt, err and st_ack clear immediately (asynchronously). No ack is produced.

Optional Feature:
- Macro IOBUS_DEC_IRQMASK_EN.
- Defined:
  - Status slot word 1 is a read/write irq mask register, NSLV bits, zero-extended on read. Reset value all ones.
  - Writes take effect the cycle after the ack.
  - Requires SW>=1.
- Undefined:
  - No mask register; irq = s_irq.
  - Word 1 reads 0 and ignores writes, but is still acked.

Test Plan:
- Read slot 2 (addr tag=BASE, slot=2); slave drives 'hCAFEBABE with ack on the 3rd strobe cycle -> s_stb=8'b00000100, m_ack and m_rdata='hCAFEBABE in that same cycle, err stays 0.
- Write to unmapped slot 10, TMO=64 -> m_ack=1 with rdata 0 exactly on the 64th strobe cycle. Next cycle err_irq=1. Status word 0 read returns bit31=1, bit30=1, low bits = the faulting address.
- Second timeout on slot 12 while err=1 -> ack at cycle 64; status err_addr still shows the slot 10 address.
- Write status word 0 -> ack one cycle after strobe; err_irq low the cycle after the ack. A subsequent status read returns 0.
- Assert rst_n low at cycle 30 of a stalled access, then release -> no m_ack, cnt=0. A fresh stalled access times out after a full 64 cycles.
- Feature on: write 'h05 to status word 1, drive s_irq='hFF -> irq='h05. Feature off: irq='hFF and word 1 reads 0.
